// File: rtl/linebuffer_window41_if.sv
// ----------------------------------------------------------------------------
// linebuffer_window41_if
// Pixel-stream / feature-vector bundle between a raster pixel source and the
// 5x8 line-buffer window generator.
//   sof       : start of frame, meaningful only together with pix_valid
//   pix_valid : pix_in carries a pixel this cycle
//   pix_in    : 32-bit unsigned pixel
//   xarray    : 41-word feature vector (bias slot + 5x8 window)
//   win_valid : one-cycle strobe, xarray holds a complete window
// master = pixel source / vector consumer, slave = line buffer.
// ----------------------------------------------------------------------------
interface linebuffer_window41_if;
    logic        sof;
    logic        pix_valid;
    logic [31:0] pix_in;
    logic [31:0] xarray [0:40];
    logic        win_valid;

    modport master (
        output sof,
        output pix_valid,
        output pix_in,
        input  xarray,
        input  win_valid
    );

    modport slave (
        input  sof,
        input  pix_valid,
        input  pix_in,
        output xarray,
        output win_valid
    );
endinterface

// File: rtl/linebuffer_window41.sv
// ----------------------------------------------------------------------------
// linebuffer_window41
// Streaming line buffer: keeps the previous four image rows, slides a
// 5-row x 8-column window across the raster and presents it, together with a
// constant bias word, as a 41-word feature vector with a one-cycle strobe.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset (control and window; line memories
//           are left untouched)
//   s_if  : slave side of linebuffer_window41_if (sof/pix_valid/pix_in in,
//           xarray/win_valid out)
// Parameter:
//   IMG_W : pixels per row, 8..4096
// ----------------------------------------------------------------------------
module linebuffer_window41 #(
    parameter int IMG_W = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    linebuffer_window41_if.slave          s_if
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROWS  = 5;
    localparam int COLS  = 8;

    // Position counters; row only needs to know "at least 4 rows seen".
    logic [COL_W-1:0] r_col;
    logic [2:0]       r_row;

    // Row memories: L1 newest completed row, L4 oldest.
    logic [31:0] r_l1 [0:IMG_W-1];
    logic [31:0] r_l2 [0:IMG_W-1];
    logic [31:0] r_l3 [0:IMG_W-1];
    logic [31:0] r_l4 [0:IMG_W-1];

    // Window: [row 0 oldest .. 4 current][col 0 oldest .. 7 newest]
    logic [31:0] r_win_p1 [0:ROWS-1][0:COLS-1];
    logic        r_vld_p1;

    logic             w_acc;
    logic             w_restart;
    logic [COL_W-1:0] w_col;
    logic [2:0]       w_row;
    logic             w_eol;
    logic [COL_W-1:0] w_col_nxt;
    logic [2:0]       w_row_nxt;
    logic             w_hit;

    // A qualified sof relocates the current pixel to (0,0) before it is used.
    always_comb begin
        w_acc     = s_if.pix_valid;
        w_restart = s_if.pix_valid & s_if.sof;
        w_col     = w_restart ? '0 : r_col;
        w_row     = w_restart ? 3'd0 : r_row;
        w_eol     = (w_col == COL_W'(IMG_W - 1));
        w_col_nxt = w_eol ? '0 : (w_col + COL_W'(1));
        w_row_nxt = (w_eol && (w_row != 3'd4)) ? (w_row + 3'd1) : w_row;
        // Columns 0..6 would straddle the previous row, so they never qualify.
        w_hit     = (w_row == 3'd4) && (w_col >= COL_W'(7));
    end

    // ---- stage p0 -> p1: counters, window shift, strobe -------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col    <= '0;
            r_row    <= 3'd0;
            r_vld_p1 <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_win_p1[r][c] <= 32'd0;
                end
            end
        end else begin
            r_vld_p1 <= w_acc & w_hit;
            if (w_acc) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS - 1; c++) begin
                        r_win_p1[r][c] <= r_win_p1[r][c+1];
                    end
                end
                r_win_p1[0][COLS-1] <= r_l4[w_col];
                r_win_p1[1][COLS-1] <= r_l3[w_col];
                r_win_p1[2][COLS-1] <= r_l2[w_col];
                r_win_p1[3][COLS-1] <= r_l1[w_col];
                r_win_p1[4][COLS-1] <= s_if.pix_in;
            end
        end
    end

    // Row cascade. Non-blocking writes make every memory read-before-write:
    // the window load above sees the values from before this pixel.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_l4[w_col] <= r_l3[w_col];
            r_l3[w_col] <= r_l2[w_col];
            r_l2[w_col] <= r_l1[w_col];
            r_l1[w_col] <= s_if.pix_in;
        end
    end

    // Feature vector: slot 0 is the constant bias term.
    always_comb begin
        s_if.xarray[0] = 32'd1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                s_if.xarray[1 + COLS*r + c] = r_win_p1[r][c];
            end
        end
    end

    assign s_if.win_valid = r_vld_p1;

endmodule

// File: tb/tb_linebuffer_window41.sv
// ----------------------------------------------------------------------------
// tb_linebuffer_window41
// Two instances (IMG_W=10 and IMG_W=8) share clock and reset. A frame-level
// model stores every accepted pixel by its frame coordinates and derives the
// expected window directly from the image; a compare process checks both DUTs
// every cycle. Directed frames add literal expectations that pin the model.
// ----------------------------------------------------------------------------
module tb_linebuffer_window41;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    linebuffer_window41_if ifa ();
    linebuffer_window41_if ifb ();

    linebuffer_window41 #(.IMG_W(10)) dut_a (.clk(clk), .rst_n(rst_n), .s_if(ifa));
    linebuffer_window41 #(.IMG_W(8))  dut_b (.clk(clk), .rst_n(rst_n), .s_if(ifb));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    function automatic int iw(input int d);
        return (d == 0) ? 10 : 8;
    endfunction

    // Per-DUT mirrors of the interface signals
    logic        pv [0:1];
    logic        sf [0:1];
    logic [31:0] px [0:1];
    logic        wv [0:1];
    logic [31:0] xa [0:1][0:40];

    always_comb begin
        pv[0] = ifa.pix_valid; sf[0] = ifa.sof; px[0] = ifa.pix_in; wv[0] = ifa.win_valid;
        pv[1] = ifb.pix_valid; sf[1] = ifb.sof; px[1] = ifb.pix_in; wv[1] = ifb.win_valid;
        for (int k = 0; k < 41; k++) begin
            xa[0][k] = ifa.xarray[k];
            xa[1][k] = ifb.xarray[k];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", nm, act, act, exp, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mrow   [0:1];
    int          mcol   [0:1];
    bit          m_vld  [0:1];
    bit          m_zero [0:1];
    bit          m_idle [0:1];
    logic [31:0] m_win  [0:1][0:40];
    logic [31:0] img    [0:1][0:7][0:15];
    logic [31:0] snap   [0:1][0:40];

    initial begin
        for (int d = 0; d < 2; d++) begin
            mrow[d] = 0; mcol[d] = 0; m_vld[d] = 0; m_zero[d] = 1; m_idle[d] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    mrow[d] = 0; mcol[d] = 0; m_vld[d] = 0; m_zero[d] = 1; m_idle[d] = 0;
                end else if (pv[d]) begin
                    if (sf[d]) begin
                        mrow[d] = 0; mcol[d] = 0;
                    end
                    img[d][mrow[d] % 8][mcol[d]] = px[d];
                    m_vld[d] = (mrow[d] >= 4) && (mcol[d] >= 7);
                    if (m_vld[d]) begin
                        for (int r = 0; r < 5; r++)
                            for (int c = 0; c < 8; c++)
                                m_win[d][1 + 8*r + c] = img[d][(mrow[d] - 4 + r) % 8][mcol[d] - 7 + c];
                    end
                    m_zero[d] = 0;
                    m_idle[d] = 0;
                    mcol[d]++;
                    if (mcol[d] == iw(d)) begin
                        mcol[d] = 0;
                        mrow[d]++;
                    end
                end else begin
                    m_vld[d]  = 0;
                    m_idle[d] = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (chk_en) begin
                    int bad;
                    chk($sformatf("win_valid dut%0d", d), {31'd0, wv[d]}, {31'd0, m_vld[d]});
                    chk($sformatf("bias dut%0d", d), xa[d][0], 32'd1);
                    if (m_vld[d]) begin
                        bad = 1;
                        for (int k = 40; k >= 1; k--) if (xa[d][k] !== m_win[d][k]) bad = k;
                        chk($sformatf("window dut%0d x%0d", d, bad), xa[d][bad], m_win[d][bad]);
                    end
                    if (m_zero[d]) begin
                        bad = 1;
                        for (int k = 40; k >= 1; k--) if (xa[d][k] !== 32'd0) bad = k;
                        chk($sformatf("reset window dut%0d x%0d", d, bad), xa[d][bad], 32'd0);
                    end
                    if (m_idle[d]) begin
                        bad = 1;
                        for (int k = 40; k >= 1; k--) if (xa[d][k] !== snap[d][k]) bad = k;
                        chk($sformatf("idle hold dut%0d x%0d", d, bad), xa[d][bad], snap[d][bad]);
                    end
                end
                for (int k = 0; k < 41; k++) snap[d][k] = xa[d][k];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int d, input logic v, input logic s, input logic [31:0] p);
        if (d == 0) begin
            ifa.pix_valid = v; ifa.sof = s; ifa.pix_in = p;
        end else begin
            ifb.pix_valid = v; ifb.sof = s; ifb.pix_in = p;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run_frame(input int d, input int rows, input int bubble_pct,
                             input bit pattern, output int pulses);
        logic [31:0] p;
        pulses = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < iw(d); c++) begin
                for (int b = 0; b < 3 && int'($urandom_range(99)) < bubble_pct; b++) begin
                    drive(d, 1'b0, 1'($urandom_range(1)), $urandom);
                    tick();
                end
                p = pattern ? 32'(16*r + c) : $urandom;
                drive(d, 1'b1, (r == 0 && c == 0), p);
                tick();
                if (wv[d]) pulses++;
                if (pattern && r >= 4) begin
                    if (r == 4 && c == 6)
                        chk($sformatf("no pulse before (4,7) dut%0d", d), {31'd0, wv[d]}, 32'd0);
                    if (c == 7) begin
                        chk($sformatf("pulse at (%0d,7) dut%0d", r, d), {31'd0, wv[d]}, 32'd1);
                        chk($sformatf("x1 at row %0d dut%0d", r, d), xa[d][1], 32'(16*(r-4)));
                        chk($sformatf("x8 at row %0d dut%0d", r, d), xa[d][8], 32'(16*(r-4) + 7));
                        chk($sformatf("x33 at row %0d dut%0d", r, d), xa[d][33], 32'(16*r));
                        chk($sformatf("x40 at row %0d dut%0d", r, d), xa[d][40], 32'(16*r + 7));
                    end
                end
            end
        end
        drive(d, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        int pl;
        int first;
        logic [31:0] v0;

        drive(0, 1'b0, 1'b0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        chk("reset win_valid", {31'd0, ifa.win_valid}, 32'd0);
        chk("reset x0", ifa.xarray[0], 32'd1);
        chk("reset x20", ifa.xarray[20], 32'd0);

        // First window and full frame, IMG_W=10, 7 rows
        run_frame(0, 7, 0, 1'b1, pl);
        chk("frame W10 H7 pulses", pl, 32'd9);
        tick();

        // Gapped random frame, 6 rows
        run_frame(0, 6, 30, 1'b0, pl);
        chk("gapped W10 H6 pulses", pl, 32'd6);
        tick();

        // Width sweep, IMG_W=8, 6 rows
        run_frame(1, 6, 0, 1'b1, pl);
        chk("frame W8 H6 pulses", pl, 32'd2);
        tick();

        // Restart at pixel (5,3)
        for (int k = 0; k < 53; k++) begin
            drive(0, 1'b1, (k == 0), $urandom);
            tick();
        end
        v0 = $urandom;
        drive(0, 1'b1, 1'b1, v0);
        tick();
        pl = wv[0] ? 1 : 0;
        for (int k = 1; k <= 47; k++) begin
            drive(0, 1'b1, 1'b0, $urandom);
            tick();
            if (k < 47 && wv[0]) pl++;
            if (k == 47) begin
                chk("restart first pulse", {31'd0, wv[0]}, 32'd1);
                chk("restart x1 = new origin", xa[0][1], v0);
            end
        end
        chk("restart pulses before (4,7)", pl, 32'd0);
        drive(0, 1'b0, 1'b0, 32'd0);
        tick();

        // Reset in the middle of a stream
        for (int k = 0; k < 25; k++) begin
            drive(0, 1'b1, 1'b0, $urandom);
            tick();
        end
        rst_n = 1'b0;
        tick();
        tick();
        chk("midreset win_valid", {31'd0, ifa.win_valid}, 32'd0);
        chk("midreset x0", ifa.xarray[0], 32'd1);
        chk("midreset x1", ifa.xarray[1], 32'd0);
        chk("midreset x40", ifa.xarray[40], 32'd0);
        rst_n = 1'b1;
        first = -1;
        for (int k = 0; k < 60; k++) begin
            drive(0, 1'b1, 1'b0, $urandom);
            tick();
            if (wv[0] && first < 0) first = k;
        end
        chk("post-reset first pulse index", 32'(first), 32'd47);

        // Random traffic on both instances, occasional sof with or without valid
        for (int k = 0; k < 600; k++) begin
            for (int d = 0; d < 2; d++)
                drive(d, ($urandom_range(99) < 75), ($urandom_range(99) < 1), $urandom);
            tick();
        end
        drive(0, 1'b0, 1'b0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
